instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Front-end fetch stage of the rv32i core: owns the program counter, issues word-aligned requests to instruction memory over a valid/ready handshake, and presents fetched {pc, instruction} pairs to `instruction_decode` through a small in-order buffer. It tolerates variable memory latency, applies back-pressure from decode, and discards in-flight fetches when execute redirects the PC on a taken branch or jump.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: capacity of the output buffer and maximum outstanding requests (in-flight plus buffered). Power of two, ≥2.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  fetch address, bits [1:0] always 0.
- `imem_rsp_valid`  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  `INSTR_WIDTH`  fetched instruction word.
- `redirect_valid`  in  1  execute redirects fetch this cycle.
- `redirect_pc`  in  32  new PC.
- `out_valid`  out  1  {out_pc, out_instr} valid toward decode.
- `out_ready`  in  1  decode consumes this cycle.
- `out_instr`  out  `INSTR_WIDTH`  instruction to `instruction_decode.instr`.
- `out_pc`  out  32  address of `out_instr`.
- `misaligned`  out  1  one-cycle pulse: last redirect target had bits [1:0] ≠ 0.

## Operation
- State: `pc` (next address to request), `inflight` (0..DEPTH), `drop` (0..DEPTH), buffer of DEPTH {pc, instr} entries with `count`.
- Issue: `imem_req_valid = !rst && !redirect_valid && (inflight + count − pop) < DEPTH`, where pop = out_valid & out_ready. `imem_req_addr = pc`.
- Request accepted (valid & ready): `pc <= pc + 4` (wraps 0xFFFF_FFFC → 0x0000_0000); `inflight` +1.
- Response: `inflight` −1. If `drop > 0`: `drop` −1, data discarded. Else push {address of that request, data} into buffer. Per-request address is kept in a DEPTH-entry address queue alongside `inflight`.
- Output: `out_valid = count != 0`; head entry drives `out_pc`/`out_instr`. Once asserted, outputs are held stable until handshake or redirect.
- Redirect: `pc <= {redirect_pc[31:2], 2'b00}`; buffer flushed (`count <= 0`); `drop <= inflight − rsp_this_cycle + drop_adjust` so every response still outstanding is discarded; no request issued this cycle; `misaligned <= |redirect_pc[1:0]`.
- Simultaneous events: redirect + output handshake → handshake completes, then flush. Redirect + response in same cycle → response discarded. Push and pop same cycle → `count` unchanged.

## Timing
- Reset values: `pc = RESET_PC`, `inflight = drop = count = 0`, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`, `misaligned = 0`, `imem_req_valid = 0` while `rst` high.
- Reset mid-operation: all state returns to reset values next edge; responses arriving after reset for pre-reset requests are not tracked (memory must be reset with the core).
- First request in the first cycle with `rst` low, address `RESET_PC`.
- Latency: request accepted at t, response at t+1 → `out_valid` at t+2.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory, `imem_req_ready = 1`, `out_ready = 1`.
- Redirect at t: first request to new target at t+1; `out_valid = 0` at t+1; first redirected instruction at t+3 with 1-cycle memory.
- Full: with `out_ready = 0`, at most DEPTH requests outstanding+buffered; `imem_req_valid` drops, no data lost.
- `imem_req_valid` may be withdrawn without handshake only by a redirect.

## Structure
- Shared `rv32i_params.vh`: `INSTR_WIDTH`, `XLEN`, `RESET_PC` default, `NOP` encoding (32'h0000_0013).
- One sub-module: `fetch_buffer`, a synchronous DEPTH-entry FIFO of {pc, instr} with push, pop, flush, count; reused for the in-flight address queue.

## Test plan
- Reset, 1-cycle memory returning addr-as-data, `out_ready = 1` → out_pc 0x0, 0x4, 0x8… one per cycle from cycle 2 after reset release.
- `out_ready = 0` for 10 cycles → exactly 2 requests issued, `imem_req_valid` low thereafter, then release → pcs 0x0, 0x4, 0x8 in order, none skipped.
- Redirect to 0x100 with 2 requests in flight → both responses dropped, next out_pc = 0x100, then 0x104.
- Redirect to 0x202 → `misaligned` pulses one cycle, next out_pc = 0x200.
- Random `imem_req_ready`/response latency 1–4 cycles, random `out_ready` → out_pc strictly sequential, out_instr matches memory model.
- `RESET_PC = 32'hFFFF_FFF8` → out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared rv32i front-end definitions used by the fetch stage and its buffers.
//   XLEN             : architectural register / address width
//   INSTR_WIDTH      : instruction word width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one buffered {pc, instr} pair handed to decode
//   align_word()     : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous DEPTH-entry FIFO. Used twice by the fetch stage: once as the
// queue of addresses still awaiting a memory response, once as the
// {pc, instr} output buffer toward decode.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO on the next edge (wins over push/pop)
//   push       : write push_data (ignored when full and not popping)
//   push_data  : entry to write
//   pop        : discard head entry (ignored when empty)
//   head       : oldest entry; only meaningful while count != 0
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front-end fetch stage of the rv32i core. Owns the PC, issues word-aligned
// requests to instruction memory, and presents in-order {pc, instr} pairs to
// decode through a DEPTH-entry buffer. A redirect from execute restarts
// fetch at the new target and discards everything fetched or still in flight.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the rising edge. A raised valid keeps its payload stable until that
// transfer; the only exception is a redirect, which may withdraw
// imem_req_valid and flushes out_valid.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req_valid/ready     : fetch request handshake, address imem_req_addr
//   imem_rsp_valid/data      : in-order memory response (>=1 cycle latency)
//   redirect_valid/pc        : execute redirects fetch this cycle
//   out_valid/ready          : handshake toward decode
//   out_instr, out_pc        : head buffer entry
//   misaligned               : one-cycle pulse, last redirect target not word aligned
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic                   misaligned
);

    localparam int              CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] rsp_addr;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            pop;
    logic            req_fire;
    logic            rsp_take;
    logic            rsp_keep;

    assign pop = out_valid && out_ready;

    // Slots already committed (in flight + buffered), crediting the entry
    // decode takes this cycle so one instruction per cycle can be sustained.
    assign occupancy = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};

    assign imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_OCC);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing tracked (e.g. stragglers from before a reset) are ignored.
    assign rsp_take   = imem_rsp_valid && (inflight != '0);
    assign rsp_keep   = rsp_take && (drop == '0) && !redirect_valid;
    assign push_entry = '{pc: rsp_addr, instr: imem_rsp_data};

    // Address of every accepted request, popped as its response returns.
    fetch_buffer #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_take),
        .head      (rsp_addr),
        .count     (inflight)
    );

    // Output buffer toward decode; a redirect empties it after any handshake
    // in the same cycle has completed.
    fetch_buffer #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            drop       <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc   <= align_word(redirect_pc);
                // Every response still owed after this cycle belongs to the old path.
                drop <= inflight - CW'(rsp_take);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (rsp_take && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;

endmodule
